mux_pipe_reg: RTL and testbench

- Parametrised N-way binary-select multiplexer with a configurable output pipeline.
- Generalises the fixed 3:1 combinational select mux in width, input count and latency.
- Adds per-stage valid tracking, stall (hold) and flush (bubble insert), and out-of-range select flagging.
- Sits between datapath sources (ALU result, memory read data, PC+4, forwarded operands) and a pipeline register boundary in the MIPS core, so the select and the register are one block.

---
 rtl/mux_pkg.sv | 17 +
 rtl/mux_pipe_stage.sv | 43 ++++
 rtl/mux_pipe_reg.sv | 100 ++++++++++
 tb/tb_mux_pipe_reg.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared limits and types for the select-and-register block.
//   MAX_IN              largest supported input count
//   MAX_STAGES          largest supported pipeline depth
//   FLUSH_BIT_DEFAULT   bit replicated to form the default flush/reset data
//   stage_flags_t       qualifier bits carried alongside each stage's data
package mux_pkg;

    localparam int   MAX_IN            = 16;
    localparam int   MAX_STAGES        = 4;
    localparam logic FLUSH_BIT_DEFAULT = 1'b0;

    typedef struct packed {
        logic valid;
        logic err;
    } stage_flags_t;

endpackage

// File: rtl/mux_pipe_stage.sv
// mux_pipe_stage: one {data, valid, err} pipeline register.
//   clk, rst_n     clock and asynchronous active-low reset
//   flush          load FLUSH_VAL / invalid bubble (wins over stall)
//   stall          hold current contents
//   load_data      next data from the previous stage
//   load_valid     next valid from the previous stage
//   load_err       next err from the previous stage
//   data, valid, err   registered stage contents
module mux_pipe_stage
    import mux_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] FLUSH_VAL = {WIDTH{FLUSH_BIT_DEFAULT}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             stall,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    input  logic             load_err,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             err
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= FLUSH_VAL;
            valid <= 1'b0;
            err   <= 1'b0;
        end else if (flush) begin
            data  <= FLUSH_VAL;
            valid <= 1'b0;
            err   <= 1'b0;
        end else if (!stall) begin
            data  <= load_data;
            valid <= load_valid;
            err   <= load_err;
        end
    end

endmodule

// File: rtl/mux_pipe_reg.sv
// mux_pipe_reg: N-way binary-select mux followed by a STAGES-deep register
// pipeline with valid tracking, stall, flush and out-of-range select flagging.
//   clk, rst_n   clock and asynchronous active-low reset
//   in_data      NUM_IN flattened inputs, input k at [k*WIDTH +: WIDTH]
//   sel          binary select, sampled together with in_data
//   in_valid     qualifies in_data/sel this cycle
//   stall        hold every stage; inputs presented meanwhile are dropped
//   flush        clear every stage to a bubble (wins over stall)
//   out_data     last-stage data
//   out_valid    last-stage valid
//   sel_err      last-stage entry was captured with sel >= NUM_IN
module mux_pipe_reg
    import mux_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               NUM_IN    = 4,
    parameter int               STAGES    = 1,
    parameter logic [WIDTH-1:0] FLUSH_VAL = {WIDTH{FLUSH_BIT_DEFAULT}},
    localparam int              SEL_W     = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    sel_err
);

    generate
        if (NUM_IN < 2 || NUM_IN > MAX_IN) begin : g_bad_num_in
            $error("mux_pipe_reg: NUM_IN must be in 2..16");
        end
        if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
            $error("mux_pipe_reg: STAGES must be in 1..4");
        end
    endgenerate

    typedef struct packed {
        logic             valid;
        logic             err;
        logic [WIDTH-1:0] data;
    } stage_t;

    // One extra bit so that NUM_IN == 2**SEL_W is representable in the compare.
    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

    logic [WIDTH-1:0] in_arr [NUM_IN];
    logic [SEL_W:0]   sel_ext;
    logic             in_range;
    logic [WIDTH-1:0] sel_data;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
        assign in_arr[k] = in_data[k*WIDTH +: WIDTH];
    end

    assign sel_ext  = {1'b0, sel};
    assign in_range = (sel_ext < NUM_IN_W);

    // Out-of-range selects fall back to input 0; the err bit records it.
    always_comb begin
        sel_data = in_arr[0];
        for (int k = 1; k < NUM_IN; k++) begin
            if (sel_ext == (SEL_W + 1)'(k)) sel_data = in_arr[k];
        end
    end

    // pipe[0] is the combinational select result; pipe[1..STAGES] are registers.
    stage_t pipe [STAGES+1];

    assign pipe[0] = '{valid: in_valid,
                       err:   in_valid & ~in_range,
                       data:  sel_data};

    for (genvar g = 1; g <= STAGES; g++) begin : g_stage
        mux_pipe_stage #(
            .WIDTH     (WIDTH),
            .FLUSH_VAL (FLUSH_VAL)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .stall      (stall),
            .load_data  (pipe[g-1].data),
            .load_valid (pipe[g-1].valid),
            .load_err   (pipe[g-1].err),
            .data       (pipe[g].data),
            .valid      (pipe[g].valid),
            .err        (pipe[g].err)
        );
    end

    assign out_data  = pipe[STAGES].data;
    assign out_valid = pipe[STAGES].valid;
    assign sel_err   = pipe[STAGES].err;

endmodule

// File: tb/tb_mux_pipe_reg.sv
// tb_mux_pipe_reg: two instances share stimulus.
//   dut_a: NUM_IN=4, STAGES=3    dut_b: NUM_IN=3, STAGES=2
module tb_mux_pipe_reg;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [4*W-1:0] din;
    logic [1:0]     sel;
    logic           in_valid;
    logic           stall;
    logic           flush;

    logic [W-1:0] a_data, b_data;
    logic         a_valid, a_err, b_valid, b_err;

    always #5 clk = ~clk;

    mux_pipe_reg #(.WIDTH(W), .NUM_IN(4), .STAGES(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(din), .sel(sel),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out_data(a_data), .out_valid(a_valid), .sel_err(a_err)
    );

    mux_pipe_reg #(.WIDTH(W), .NUM_IN(3), .STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(din[3*W-1:0]), .sel(sel),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .out_data(b_data), .out_valid(b_valid), .sel_err(b_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    function automatic exp_t expect_for(input logic [4*W-1:0] d, input logic [1:0] s, input int n);
        exp_t e;
        int   idx;
        idx = int'(s);
        if (idx < n) begin
            e.data = d[idx*W +: W];
            e.err  = 1'b0;
        end else begin
            e.data = d[W-1:0];
            e.err  = 1'b1;
        end
        return e;
    endfunction

    task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard, sampled on the falling edge where inputs and outputs are stable.
    // An output entry with stall=0 and flush=0 leaves at the next rising edge and
    // is compared then; an accepted input is pushed. Flush/reset discard in-flight.
    exp_t ea, eb;
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            q_a.delete();
            q_b.delete();
        end else if (!stall) begin
            if (a_valid) begin
                checks++;
                assert (q_a.size() > 0) else begin
                    errors++;
                    $error("FAIL sb_a_unexpected: observed valid data %h expected no entry", a_data);
                end
                if (q_a.size() > 0) begin
                    ea = q_a.pop_front();
                    check_word("sb_a_data", a_data, ea.data);
                    check_bit("sb_a_err", a_err, ea.err);
                end
            end
            if (b_valid) begin
                checks++;
                assert (q_b.size() > 0) else begin
                    errors++;
                    $error("FAIL sb_b_unexpected: observed valid data %h expected no entry", b_data);
                end
                if (q_b.size() > 0) begin
                    eb = q_b.pop_front();
                    check_word("sb_b_data", b_data, eb.data);
                    check_bit("sb_b_err", b_err, eb.err);
                end
            end
            if (in_valid) begin
                q_a.push_back(expect_for(din, sel, 4));
                q_b.push_back(expect_for(din, sel, 3));
            end
        end
    end

    logic [W-1:0] lat_exp [4];

    initial begin
        lat_exp[0] = 32'h1111_1111;
        lat_exp[1] = 32'h2222_2222;
        lat_exp[2] = 32'h3333_3333;
        lat_exp[3] = 32'h4444_4444;

        rst_n = 1'b0; din = '0; sel = 2'd0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        #2;
        check_word("rst_a_data", a_data, '0);
        check_bit ("rst_a_valid", a_valid, 1'b0);
        check_bit ("rst_a_err", a_err, 1'b0);
        check_word("rst_b_data", b_data, '0);
        check_bit ("rst_b_valid", b_valid, 1'b0);
        check_bit ("rst_b_err", b_err, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Latency and select sweep
        din = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                sel = 2'(k);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (k >= 2 && k <= 5) begin
                check_word("lat_a_data", a_data, lat_exp[k-2]);
                check_bit ("lat_a_valid", a_valid, 1'b1);
            end
        end
        check_bit("lat_a_bubble", a_valid, 1'b0);

        // Out-of-range select on the 3-input instance
        din[W-1:0] = 32'hAAAA_0000;
        sel = 2'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check_word("oor_b_data", b_data, 32'hAAAA_0000);
        check_bit ("oor_b_valid", b_valid, 1'b1);
        check_bit ("oor_b_err", b_err, 1'b1);
        step();
        check_bit ("oor_b_inv_valid", b_valid, 1'b0);
        check_bit ("oor_b_inv_err", b_err, 1'b0);

        // Stall mid-stream
        sel = 2'd0;
        for (int v = 1; v <= 2; v++) begin
            din[W-1:0] = W'(v);
            in_valid = 1'b1;
            step();
        end
        stall = 1'b1;
        din[W-1:0] = 32'd99;
        for (int i = 0; i < 3; i++) begin
            step();
            check_word("stall_b_data", b_data, 32'd1);
            check_bit ("stall_b_valid", b_valid, 1'b1);
            check_bit ("stall_a_valid", a_valid, 1'b0);
        end
        stall = 1'b0;
        for (int v = 3; v <= 5; v++) begin
            din[W-1:0] = W'(v);
            step();
            check_word("resume_b_data", b_data, W'(v - 1));
        end
        in_valid = 1'b0;
        step();
        check_word("resume_b_last", b_data, 32'd5);
        check_bit ("resume_b_valid", b_valid, 1'b1);
        repeat (3) step();

        // Flush together with stall
        din[W-1:0] = 32'd7;
        in_valid = 1'b1;
        step();
        din[W-1:0] = 32'd8;
        step();
        check_bit("pre_flush_b_valid", b_valid, 1'b1);
        flush = 1'b1;
        stall = 1'b1;
        din[W-1:0] = 32'd9;
        step();
        check_bit ("flush_b_valid", b_valid, 1'b0);
        check_word("flush_b_data", b_data, '0);
        check_bit ("flush_a_valid", a_valid, 1'b0);
        check_word("flush_a_data", a_data, '0);
        flush = 1'b0;
        stall = 1'b0;
        din[W-1:0] = 32'd10;
        step();
        check_bit("post_flush_b_bubble", b_valid, 1'b0);
        in_valid = 1'b0;
        step();
        check_word("post_flush_b_data", b_data, 32'd10);
        check_bit ("post_flush_b_valid", b_valid, 1'b1);
        repeat (3) step();

        // Unqualified data is not gated
        din[2*W-1:W] = 32'hDEAD_BEEF;
        sel = 2'd1;
        in_valid = 1'b0;
        step();
        step();
        check_bit ("gate_b_valid", b_valid, 1'b0);
        check_word("gate_b_data", b_data, 32'hDEAD_BEEF);
        step();
        check_bit ("gate_a_valid", a_valid, 1'b0);
        check_word("gate_a_data", a_data, 32'hDEAD_BEEF);

        // Reset with entries in flight
        sel = 2'd0;
        din[W-1:0] = 32'h100;
        in_valid = 1'b1;
        step();
        din[W-1:0] = 32'h101;
        step();
        check_bit("pre_rst_b_valid", b_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_word("mrst_a_data", a_data, '0);
        check_bit ("mrst_a_valid", a_valid, 1'b0);
        check_bit ("mrst_a_err", a_err, 1'b0);
        check_word("mrst_b_data", b_data, '0);
        check_bit ("mrst_b_valid", b_valid, 1'b0);
        check_bit ("mrst_b_err", b_err, 1'b0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_bit("post_rst_a_idle", a_valid, 1'b0);
            check_bit("post_rst_b_idle", b_valid, 1'b0);
        end
        din[W-1:0] = 32'h55;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check_word("post_rst_b_data", b_data, 32'h55);
        check_bit ("post_rst_b_valid", b_valid, 1'b1);
        step();
        check_word("post_rst_a_data", a_data, 32'h55);
        check_bit ("post_rst_a_valid", a_valid, 1'b1);

        // Drain and confirm nothing was lost
        repeat (5) step();
        check_word("drain_a_left", W'(q_a.size()), '0);
        check_word("drain_b_left", W'(q_b.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
